// File: rtl/validador_frota.sv
// validador_frota: ship placement validator for N_JOG players.
// Builds the candidate occupancy mask, checks borders and fleet capacity,
// scans the player's stored masks in external RAM, and writes the mask on success.
// Optional macro FROTA_ADJACENCIA_EN: scan against a one-cell dilated mask so ships may not touch.
module validador_frota #(
  parameter int unsigned BOARD_W    = 8,
  parameter int unsigned BOARD_H    = 8,
  parameter int unsigned MAX_NAVIOS = 11,
  parameter int unsigned N_JOG      = 2,
  parameter int unsigned COORD_W    = 4,
  parameter int unsigned ADDR_W     = 4,
  parameter int unsigned JOG_W      = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic                       limpar,
  input  logic [JOG_W-1:0]           jogador,
  input  logic [2:0]                 tipo,
  input  logic                       direcao,
  input  logic [1:0]                 orientacao,
  input  logic [COORD_W-1:0]         x1,
  input  logic [COORD_W-1:0]         y1,
  output logic [JOG_W-1:0]           rd_jogador,
  output logic [ADDR_W-1:0]          rd_addr,
  input  logic [BOARD_W*BOARD_H-1:0] rd_data,
  output logic                       wr_en,
  output logic [JOG_W-1:0]           wr_jogador,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic [BOARD_W*BOARD_H-1:0] wr_data,
  output logic                       ready,
  output logic                       conflito,
  output logic                       conflitoBorda_out,
  output logic                       conflitoMemoria_out,
  output logic                       conflitoCheio_out,
  output logic [ADDR_W:0]            qtd_navios
);

  localparam int unsigned CELLS = BOARD_W * BOARD_H;
  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned CW    = COORD_W + 3;
  localparam int unsigned IDX_W = (CELLS > 1) ? $clog2(CELLS) : 1;

  typedef enum logic [2:0] {IDLE, BUILD, SCAN, WRITE, DONE} state_t;

  state_t               state_q, state_d;
  logic                 enable_q;
  logic [2:0]           tipo_q, tipo_d;
  logic                 dir_q, dir_d;
  logic [1:0]           ori_q, ori_d;
  logic [COORD_W-1:0]   x_q, x_d, y_q, y_d;
  logic [JOG_W-1:0]     jog_q, jog_d;
  logic [CELLS-1:0]     mask_q, mask_d, mask_c, scan_mask;
  logic [CNT_W-1:0]     scan_k_q, scan_k_d;
  logic [CNT_W-1:0]     cnt_q [N_JOG];
  logic [CNT_W-1:0]     cnt_d [N_JOG];
  logic [CNT_W-1:0]     cur_cnt;
  logic                 borda_c;
  logic [JOG_W-1:0]     rd_jog_d, wr_jog_d;
  logic [ADDR_W-1:0]    rd_addr_d, wr_addr_d;
  logic [CELLS-1:0]     wr_data_d;
  logic                 wr_en_d, ready_d;
  logic                 confl_d, borda_d, mem_d, cheio_d;
  logic [CNT_W-1:0]     qtd_d;

  logic [CW-1:0]        cx [5];
  logic [CW-1:0]        cy [5];
  logic [4:0]           used;
  logic [2:0]           len;
  logic [CW-1:0]        xe, ye;

  // Candidate cell list and occupancy mask from the latched request
  always_comb begin
    mask_c  = '0;
    borda_c = 1'b0;
    used    = '0;
    len     = 3'd0;
    xe      = CW'(x_q);
    ye      = CW'(y_q);
    for (int i = 0; i < 5; i++) begin
      cx[i] = '0;
      cy[i] = '0;
    end
    case (tipo_q)
      3'd0, 3'd1, 3'd3, 3'd4: begin
        case (tipo_q)
          3'd0:    len = 3'd1;
          3'd1:    len = 3'd2;
          3'd3:    len = 3'd4;
          default: len = 3'd5;
        endcase
        for (int i = 0; i < 5; i++) begin
          if (3'(i) < len) begin
            used[i] = 1'b1;
            cx[i]   = dir_q ? xe : xe + CW'(i);
            cy[i]   = dir_q ? ye + CW'(i) : ye;
          end
        end
      end
      3'd2: begin
        used = 5'b00111;
        case (ori_q)
          2'd0: begin
            cx[0] = xe;          cy[0] = ye + CW'(1);
            cx[1] = xe + CW'(1); cy[1] = ye;
            cx[2] = xe + CW'(2); cy[2] = ye + CW'(1);
          end
          2'd1: begin
            cx[0] = xe;          cy[0] = ye;
            cx[1] = xe + CW'(1); cy[1] = ye + CW'(1);
            cx[2] = xe + CW'(2); cy[2] = ye;
          end
          2'd2: begin
            cx[0] = xe + CW'(1); cy[0] = ye;
            cx[1] = xe;          cy[1] = ye + CW'(1);
            cx[2] = xe + CW'(1); cy[2] = ye + CW'(2);
          end
          default: begin
            cx[0] = xe;          cy[0] = ye;
            cx[1] = xe + CW'(1); cy[1] = ye + CW'(1);
            cx[2] = xe;          cy[2] = ye + CW'(2);
          end
        endcase
      end
      default: borda_c = 1'b1;
    endcase
    for (int i = 0; i < 5; i++) begin
      if (used[i]) begin
        if (cx[i] >= CW'(BOARD_W) || cy[i] >= CW'(BOARD_H)) begin
          borda_c = 1'b1;
        end else begin
          mask_c[IDX_W'(int'(cy[i]) * int'(BOARD_W) + int'(cx[i]))] = 1'b1;
        end
      end
    end
  end

`ifdef FROTA_ADJACENCIA_EN
  // Dilate the stored candidate by one cell in all 8 directions, clipped at the edges
  always_comb begin
    scan_mask = '0;
    for (int y = 0; y < int'(BOARD_H); y++) begin
      for (int x = 0; x < int'(BOARD_W); x++) begin
        if (mask_q[IDX_W'(y * int'(BOARD_W) + x)]) begin
          for (int dy = -1; dy <= 1; dy++) begin
            for (int dx = -1; dx <= 1; dx++) begin
              if ((y + dy) >= 0 && (y + dy) < int'(BOARD_H) &&
                  (x + dx) >= 0 && (x + dx) < int'(BOARD_W)) begin
                scan_mask[IDX_W'((y + dy) * int'(BOARD_W) + (x + dx))] = 1'b1;
              end
            end
          end
        end
      end
    end
  end
`else
  assign scan_mask = mask_q;
`endif

  // Ship count of the player owning the current request
  always_comb begin
    cur_cnt = '0;
    for (int j = 0; j < int'(N_JOG); j++) begin
      if (JOG_W'(j) == jog_q) cur_cnt = cnt_q[j];
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d   = state_q;
    tipo_d    = tipo_q;
    dir_d     = dir_q;
    ori_d     = ori_q;
    x_d       = x_q;
    y_d       = y_q;
    jog_d     = jog_q;
    mask_d    = mask_q;
    scan_k_d  = scan_k_q;
    rd_jog_d  = rd_jogador;
    rd_addr_d = rd_addr;
    wr_jog_d  = wr_jogador;
    wr_addr_d = wr_addr;
    wr_data_d = wr_data;
    wr_en_d   = 1'b0;
    ready_d   = 1'b0;
    confl_d   = conflito;
    borda_d   = conflitoBorda_out;
    mem_d     = conflitoMemoria_out;
    cheio_d   = conflitoCheio_out;
    for (int j = 0; j < int'(N_JOG); j++) cnt_d[j] = cnt_q[j];

    case (state_q)
      IDLE: begin
        if (limpar) begin
          for (int j = 0; j < int'(N_JOG); j++) cnt_d[j] = '0;
        end else if (enable && !enable_q) begin
          tipo_d  = tipo;
          dir_d   = direcao;
          ori_d   = orientacao;
          x_d     = x1;
          y_d     = y1;
          jog_d   = jogador;
          confl_d = 1'b0;
          borda_d = 1'b0;
          mem_d   = 1'b0;
          cheio_d = 1'b0;
          state_d = BUILD;
        end
      end
      BUILD: begin
        mask_d = mask_c;
        if (borda_c) begin
          borda_d = 1'b1;
          confl_d = 1'b1;
          state_d = DONE;
        end else if (cur_cnt >= CNT_W'(MAX_NAVIOS)) begin
          cheio_d = 1'b1;
          confl_d = 1'b1;
          state_d = DONE;
        end else if (cur_cnt == '0) begin
          wr_en_d   = 1'b1;
          wr_jog_d  = jog_q;
          wr_addr_d = ADDR_W'(cur_cnt);
          wr_data_d = mask_c;
          state_d   = WRITE;
        end else begin
          rd_jog_d  = jog_q;
          rd_addr_d = '0;
          scan_k_d  = '0;
          state_d   = SCAN;
        end
      end
      SCAN: begin
        // rd_data in cycle k belongs to address k-1
        scan_k_d = scan_k_q + CNT_W'(1);
        if (scan_k_q != '0 && |(rd_data & scan_mask)) begin
          mem_d   = 1'b1;
          confl_d = 1'b1;
          state_d = DONE;
        end else if (scan_k_q == cur_cnt) begin
          wr_en_d   = 1'b1;
          wr_jog_d  = jog_q;
          wr_addr_d = ADDR_W'(cur_cnt);
          wr_data_d = mask_q;
          state_d   = WRITE;
        end else if ((scan_k_q + CNT_W'(1)) < cur_cnt) begin
          rd_addr_d = ADDR_W'(scan_k_q + CNT_W'(1));
        end
      end
      WRITE: begin
        for (int j = 0; j < int'(N_JOG); j++) begin
          if (JOG_W'(j) == jog_q && cnt_q[j] < CNT_W'(MAX_NAVIOS)) begin
            cnt_d[j] = cnt_q[j] + CNT_W'(1);
          end
        end
        state_d = DONE;
      end
      DONE: begin
        ready_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    qtd_d = '0;
    for (int j = 0; j < int'(N_JOG); j++) begin
      if (JOG_W'(j) == jogador) qtd_d = cnt_d[j];
    end
  end

  // State, request latches, counters and outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q             <= IDLE;
      enable_q            <= 1'b0;
      tipo_q              <= '0;
      dir_q               <= 1'b0;
      ori_q               <= '0;
      x_q                 <= '0;
      y_q                 <= '0;
      jog_q               <= '0;
      mask_q              <= '0;
      scan_k_q            <= '0;
      for (int j = 0; j < int'(N_JOG); j++) cnt_q[j] <= '0;
      rd_jogador          <= '0;
      rd_addr             <= '0;
      wr_jogador          <= '0;
      wr_addr             <= '0;
      wr_data             <= '0;
      wr_en               <= 1'b0;
      ready               <= 1'b0;
      conflito            <= 1'b0;
      conflitoBorda_out   <= 1'b0;
      conflitoMemoria_out <= 1'b0;
      conflitoCheio_out   <= 1'b0;
      qtd_navios          <= '0;
    end else begin
      state_q             <= state_d;
      enable_q            <= enable;
      tipo_q              <= tipo_d;
      dir_q               <= dir_d;
      ori_q               <= ori_d;
      x_q                 <= x_d;
      y_q                 <= y_d;
      jog_q               <= jog_d;
      mask_q              <= mask_d;
      scan_k_q            <= scan_k_d;
      for (int j = 0; j < int'(N_JOG); j++) cnt_q[j] <= cnt_d[j];
      rd_jogador          <= rd_jog_d;
      rd_addr             <= rd_addr_d;
      wr_jogador          <= wr_jog_d;
      wr_addr             <= wr_addr_d;
      wr_data             <= wr_data_d;
      wr_en               <= wr_en_d;
      ready               <= ready_d;
      conflito            <= confl_d;
      conflitoBorda_out   <= borda_d;
      conflitoMemoria_out <= mem_d;
      conflitoCheio_out   <= cheio_d;
      qtd_navios          <= qtd_d;
    end
  end

endmodule

// File: tb/tb_validador_frota.sv
// Directed bench for validador_frota with a behavioural synchronous RAM.
module tb_validador_frota;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable, limpar;
  logic [0:0]  jogador;
  logic [2:0]  tipo;
  logic        direcao;
  logic [1:0]  orientacao;
  logic [3:0]  x1, y1;
  logic [0:0]  rd_jogador, wr_jogador;
  logic [3:0]  rd_addr, wr_addr;
  logic [63:0] rd_data, wr_data;
  logic        wr_en, ready, conflito;
  logic        conflitoBorda_out, conflitoMemoria_out, conflitoCheio_out;
  logic [4:0]  qtd_navios;

  int n_cmp = 0;
  int n_err = 0;

  // Captured per-request results
  int          lat;
  logic        saw_wr;
  logic [3:0]  wa;
  logic [0:0]  wj;
  logic [63:0] wd;
  logic        r_confl, r_b, r_m, r_c;
  int          exp_cnt;

  logic [3:0] fx [9] = '{4'd0, 4'd2, 4'd4, 4'd6, 4'd0, 4'd2, 4'd4, 4'd6, 4'd6};
  logic [3:0] fy [9] = '{4'd5, 4'd5, 4'd5, 4'd5, 4'd7, 4'd7, 4'd7, 4'd7, 4'd3};

  logic [63:0] mem [2][16];

  validador_frota dut (
    .clk(clk), .rst(rst), .enable(enable), .limpar(limpar), .jogador(jogador),
    .tipo(tipo), .direcao(direcao), .orientacao(orientacao), .x1(x1), .y1(y1),
    .rd_jogador(rd_jogador), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_jogador(wr_jogador), .wr_addr(wr_addr), .wr_data(wr_data),
    .ready(ready), .conflito(conflito), .conflitoBorda_out(conflitoBorda_out),
    .conflitoMemoria_out(conflitoMemoria_out), .conflitoCheio_out(conflitoCheio_out),
    .qtd_navios(qtd_navios)
  );

  always #5 clk = ~clk;

  // Synchronous RAM: read data valid one cycle after address
  always @(posedge clk) begin
    if (wr_en) mem[wr_jogador][wr_addr] <= wr_data;
    rd_data <= mem[rd_jogador][rd_addr];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one request, measure latency to ready, optionally hold enable afterwards
  task automatic do_req(input logic [0:0] j, input logic [2:0] t, input logic d,
                        input logic [1:0] o, input logic [3:0] x, input logic [3:0] y,
                        input int hold);
    @(negedge clk);
    jogador = j; tipo = t; direcao = d; orientacao = o; x1 = x; y1 = y;
    enable = 1'b1;
    @(posedge clk);
    lat = 0; saw_wr = 1'b0; wa = '0; wj = '0; wd = '0;
    while (lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (wr_en) begin
        saw_wr = 1'b1; wa = wr_addr; wj = wr_jogador; wd = wr_data;
      end
      if (ready) break;
    end
    if (lat >= 40) chk("req_timeout", 64'(ready), 64'd1);
    r_confl = conflito; r_b = conflitoBorda_out; r_m = conflitoMemoria_out; r_c = conflitoCheio_out;
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      chk("no_retrigger", 64'(ready), 64'd0);
    end
    @(negedge clk);
    enable = 1'b0;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; limpar = 1'b0; jogador = '0; tipo = '0;
    direcao = 1'b0; orientacao = '0; x1 = '0; y1 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 64'(ready), 64'd0);
    chk("rst_wr_en", 64'(wr_en), 64'd0);
    chk("rst_conflito", 64'(conflito), 64'd0);
    chk("rst_qtd", 64'(qtd_navios), 64'd0);
    chk("rst_wr_data", wr_data, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Single submarino, empty fleet
    do_req(1'b0, 3'd0, 1'b0, 2'd0, 4'd2, 4'd3, 3);
    chk("r1_lat", 64'(lat), 64'd3);
    chk("r1_wr", 64'(saw_wr), 64'd1);
    chk("r1_wa", 64'(wa), 64'd0);
    chk("r1_wd", wd, 64'h0000_0000_0400_0000);
    chk("r1_confl", 64'(r_confl), 64'd0);
    chk("r1_qtd", 64'(qtd_navios), 64'd1);

    // Cruzador off the right edge
    do_req(1'b0, 3'd1, 1'b0, 2'd0, 4'd7, 4'd0, 0);
    chk("r2_lat", 64'(lat), 64'd2);
    chk("r2_wr", 64'(saw_wr), 64'd0);
    chk("r2_borda", 64'(r_b), 64'd1);
    chk("r2_confl", 64'(r_confl), 64'd1);
    chk("r2_qtd", 64'(qtd_navios), 64'd1);

    // Same cell again for player 0 overlaps slot 0
    do_req(1'b0, 3'd0, 1'b0, 2'd0, 4'd2, 4'd3, 0);
    chk("r3_lat", 64'(lat), 64'd4);
    chk("r3_mem", 64'(r_m), 64'd1);
    chk("r3_borda", 64'(r_b), 64'd0);
    chk("r3_wr", 64'(saw_wr), 64'd0);
    chk("r3_qtd", 64'(qtd_navios), 64'd1);

    // Same cell for player 1 is independent
    do_req(1'b1, 3'd0, 1'b0, 2'd0, 4'd2, 4'd3, 0);
    chk("r4_lat", 64'(lat), 64'd3);
    chk("r4_wj", 64'(wj), 64'd1);
    chk("r4_wa", 64'(wa), 64'd0);
    chk("r4_confl", 64'(r_confl), 64'd0);

    // Hidroaviao orientation 1 at origin for player 0
    do_req(1'b0, 3'd2, 1'b0, 2'd1, 4'd0, 4'd0, 0);
    chk("r5_lat", 64'(lat), 64'd5);
    chk("r5_wa", 64'(wa), 64'd1);
    chk("r5_wd", wd, 64'h205);
    chk("r5_confl", 64'(r_confl), 64'd0);
    chk("r5_qtd", 64'(qtd_navios), 64'd2);
    @(negedge clk); jogador = 1'b1;
    @(posedge clk); #1;
    chk("p1_qtd", 64'(qtd_navios), 64'd1);

    // Submarino touching the hidroaviao at (1,0)
    do_req(1'b0, 3'd0, 1'b0, 2'd0, 4'd1, 4'd0, 0);
`ifdef FROTA_ADJACENCIA_EN
    chk("r6_lat", 64'(lat), 64'd5);
    chk("r6_mem", 64'(r_m), 64'd1);
    chk("r6_wr", 64'(saw_wr), 64'd0);
    exp_cnt = 2;
`else
    chk("r6_lat", 64'(lat), 64'd6);
    chk("r6_wa", 64'(wa), 64'd2);
    chk("r6_wd", wd, 64'h2);
    chk("r6_confl", 64'(r_confl), 64'd0);
    exp_cnt = 3;
`endif

    // Fill player 0 to capacity with isolated submarinos
    for (int i = 0; i < 9; i++) begin
      if (exp_cnt < 11) begin
        do_req(1'b0, 3'd0, 1'b0, 2'd0, fx[i], fy[i], 0);
        chk("fill_confl", 64'(r_confl), 64'd0);
        chk("fill_wa", 64'(wa), 64'(exp_cnt));
        exp_cnt++;
      end
    end
    chk("fill_qtd", 64'(qtd_navios), 64'd11);

    // Twelfth ship rejected as full
    do_req(1'b0, 3'd0, 1'b0, 2'd0, 4'd5, 4'd1, 0);
    chk("full_lat", 64'(lat), 64'd2);
    chk("full_cheio", 64'(r_c), 64'd1);
    chk("full_wr", 64'(saw_wr), 64'd0);
    chk("full_qtd", 64'(qtd_navios), 64'd11);

    // Border takes precedence over full
    do_req(1'b0, 3'd4, 1'b1, 2'd0, 4'd0, 4'd5, 0);
    chk("prec_borda", 64'(r_b), 64'd1);
    chk("prec_cheio", 64'(r_c), 64'd0);

    // Invalid tipo is a border conflict
    do_req(1'b0, 3'd7, 1'b0, 2'd0, 4'd0, 4'd0, 0);
    chk("inv_borda", 64'(r_b), 64'd1);
    chk("inv_lat", 64'(lat), 64'd2);

    // Clear all counters
    @(negedge clk); limpar = 1'b1;
    @(posedge clk); #1;
    chk("clr_qtd0", 64'(qtd_navios), 64'd0);
    @(negedge clk); limpar = 1'b0; jogador = 1'b1;
    @(posedge clk); #1;
    chk("clr_qtd1", 64'(qtd_navios), 64'd0);

    // Four ships for player 1
    for (int i = 0; i < 4; i++) begin
      do_req(1'b1, 3'd0, 1'b0, 2'd0, 4'(2 * i), 4'd0, 0);
      chk("p1_fill_wa", 64'(wa), 64'(i));
    end
    chk("p1_fill_qtd", 64'(qtd_navios), 64'd4);

    // Reset in the middle of a four-entry scan
    @(negedge clk);
    jogador = 1'b1; tipo = 3'd0; direcao = 1'b0; x1 = 4'd0; y1 = 4'd2; enable = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("scan_rd_addr", 64'(rd_addr), 64'd1);
    chk("scan_rd_jog", 64'(rd_jogador), 64'd1);
    rst = 1'b1;
    #1;
    chk("mrst_ready", 64'(ready), 64'd0);
    chk("mrst_wr_en", 64'(wr_en), 64'd0);
    chk("mrst_rd_addr", 64'(rd_addr), 64'd0);
    chk("mrst_wr_addr", 64'(wr_addr), 64'd0);
    chk("mrst_wr_data", wr_data, 64'd0);
    chk("mrst_qtd", 64'(qtd_navios), 64'd0);
    chk("mrst_flags", 64'({conflito, conflitoBorda_out, conflitoMemoria_out, conflitoCheio_out}), 64'd0);
    @(negedge clk); rst = 1'b0; enable = 1'b0;

    // After reset the next ship lands in slot 0
    do_req(1'b1, 3'd0, 1'b0, 2'd0, 4'd0, 4'd2, 0);
    chk("post_lat", 64'(lat), 64'd3);
    chk("post_wr", 64'(saw_wr), 64'd1);
    chk("post_wa", 64'(wa), 64'd0);
    chk("post_qtd", 64'(qtd_navios), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/validador_frota.md
Name: validador_frota

Overview:
- Parametrised successor to the single-board ship placement validator.
- Accepts one ship placement request (type, anchor, direction, orientation, player) and builds a BOARD_W×BOARD_H occupancy mask for it.
- Checks the mask against board borders, then scans that player's stored ship masks in external RAM.
- On success, writes the new mask to RAM. Supports N_JOG players, each with its own ship counter and RAM region.

Parameters:
BOARD_W, 8, board columns
BOARD_H, 8, board rows
MAX_NAVIOS, 11, ship slots per player
N_JOG, 2, number of players
COORD_W, 4, width of x1/y1
ADDR_W, 4, width of per-player slot address (≥ clog2(MAX_NAVIOS))
JOG_W, 1, width of player select (≥ clog2(N_JOG))

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
enable  in  1  level request; a new request starts on a 0→1 transition sampled at clk
limpar  in  1  synchronous clear of all player counters; accepted only in IDLE
jogador  in  JOG_W  player select
tipo  in  3  0 submarino(1), 1 cruzador(2), 2 hidroaviao(3, V), 3 encouracado(4), 4 porta-avioes(5), 5-7 invalid
direcao  in  1  0 = line along +x, 1 = line along +y
orientacao  in  2  hidroaviao orientation
x1, y1  in  COORD_W  anchor cell
rd_jogador, rd_addr  out  JOG_W, ADDR_W  RAM read address
rd_data  in  BOARD_W*BOARD_H  RAM read data, valid one cycle after address
wr_en  out  1  one-cycle RAM write strobe
wr_jogador, wr_addr  out  JOG_W, ADDR_W  RAM write address
wr_data  out  BOARD_W*BOARD_H  candidate mask
ready  out  1  one-cycle done pulse
conflito  out  1  OR of the three flags below
conflitoBorda_out  out  1  cell off-board, or invalid tipo
conflitoMemoria_out  out  1  overlap with a stored ship
conflitoCheio_out  out  1  player already holds MAX_NAVIOS ships
qtd_navios  out  ADDR_W+1  count for the currently selected jogador

Behaviour:
- Bit index for cell (x,y) = y*BOARD_W + x. Cell arithmetic uses COORD_W+3 bits, so no wrap. Any cell with x≥BOARD_W or y≥BOARD_H sets conflitoBorda_out.
- Hidroaviao cells:
  - orientacao 0: (x,y+1), (x+1,y), (x+2,y+1)
  - orientacao 1: (x,y), (x+1,y+1), (x+2,y)
  - orientacao 2: (x+1,y), (x,y+1), (x+1,y+2)
  - orientacao 3: (x,y), (x+1,y+1), (x,y+2)
- FSM states: IDLE, BUILD, SCAN, WRITE, DONE.
  - IDLE: on enable rise, latch all inputs → BUILD. If limpar is high, zero all counters instead; limpar has priority over an enable rise.
  - BUILD (1 cycle): compute mask and border flag.
    - Border conflict → DONE (border takes precedence over full).
    - Else counter==MAX_NAVIOS → DONE with conflitoCheio_out.
    - Else counter==0 → WRITE.
    - Else → SCAN.
  - SCAN: issue rd_addr 0..cnt-1, one per cycle. Compare rd_data & mask one cycle later.
    - First nonzero result → set conflitoMemoria_out, → DONE (early exit; remaining reads discarded).
    - Last compare clean → WRITE.
  - WRITE (1 cycle): wr_en=1, wr_addr=counter, wr_data=mask; counter increments at end of cycle → DONE.
  - DONE (1 cycle): ready=1 → IDLE.
- Conflict flags and conflito are updated on entry to DONE and held until the next accepted request. Starting a new request clears them.
- Latency from the accepting edge to ready high:
  - 3 cycles with cnt=0.
  - 3+cnt+1 cycles for a clean scan with cnt>0.
  - 2 cycles for a border or full reject.
- enable held high after ready does not retrigger. Inputs other than enable are don't-care after acceptance.
- Reset (any time, including mid-SCAN): state IDLE; ready, wr_en, all flags, rd/wr addresses and data 0; all counters 0. RAM content is not cleared but is ignored via the counters.
- Counters saturate at MAX_NAVIOS; no write ever occurs at or beyond MAX_NAVIOS.

Optional Feature:
FROTA_ADJACENCIA_EN:
- Defined: SCAN compares rd_data against the candidate mask dilated by one cell in all 8 directions, clipped at board edges, so ships may not touch, including diagonally. wr_data remains the undilated mask.
- Undefined: pure overlap check only.

Test Plan:
- Reset, jogador 0, tipo 0 at (2,3): ready 3 cycles after enable rise; wr_addr 0; wr_data bit 26 only; conflito=0; qtd_navios=1.
- Cruzador direcao 0 at (7,0) on 8×8: conflitoBorda_out=1; no wr_en; ready at 2 cycles; counter unchanged.
- Submarino at (2,3) again for jogador 0: conflitoMemoria_out=1 after the read of addr 0. For jogador 1: accepted, jogador 0 count unchanged.
- Hidroaviao orientacao 1 at (0,0), then tipo 0 at (1,0): second request is clean without FROTA_ADJACENCIA_EN and conflicts with it.
- Fill jogador 0 to 11 ships, request a 12th: conflitoCheio_out=1, no wr_en. Pulse limpar: qtd_navios=0.
- Assert rst mid-SCAN with cnt=4: all outputs 0 immediately. A following request writes to addr 0.
